universal_shift_reg: RTL

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

---
 rtl/universal_shift_reg_pkg.sv | 28 ++
 rtl/universal_shift_reg_step_counter.sv | 54 +++++
 rtl/universal_shift_reg.sv | 73 +++++++
 3 files changed

// File: rtl/universal_shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode encoding and
// helpers that classify a mode for the step counter.
package universal_shift_reg_pkg;

  localparam int unsigned MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD   = 3'd0,
    MODE_LOAD   = 3'd1,
    MODE_SHL    = 3'd2,
    MODE_SHR    = 3'd3,
    MODE_ROL    = 3'd4,
    MODE_ROR    = 3'd5,
    MODE_CLEAR  = 3'd6,
    MODE_INVERT = 3'd7
  } mode_e;

  // Shift and rotate operations advance the step count.
  function automatic logic is_step(input mode_e m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) || (m == MODE_ROR);
  endfunction

  // Load and clear start a fresh word.
  function automatic logic is_clear(input mode_e m);
    return (m == MODE_LOAD) || (m == MODE_CLEAR);
  endfunction

endpackage

// File: rtl/universal_shift_reg_step_counter.sv
// Counts shift/rotate steps since the last load/clear/reset and pulses
// done_o for one cycle when a full word of WIDTH steps has been shifted.
module usr_step_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic                   step_i,
  input  logic                   clear_i,
  output logic [$clog2(WIDTH):0] count_o,
  output logic                   done_o
);

  localparam int unsigned   CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] count_q, count_d;
  logic          done_q, done_d;

  // Next count and done pulse; done is only ever high for the cycle after the
  // wrapping step, and drops whenever the enable is low.
  always_comb begin
    count_d = count_q;
    done_d  = 1'b0;
    if (en_i) begin
      if (clear_i) begin
        count_d = '0;
      end else if (step_i) begin
        if (count_q == LAST) begin
          count_d = '0;
          done_d  = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
    end
  end

  // Counter state register with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign count_o = count_q;
  assign done_o  = done_q;

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, load, shift, rotate, clear and invert,
// with a step counter that flags each completed word.
module universal_shift_reg
  import universal_shift_reg_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Enable,
  input  logic [MODE_W-1:0]      Mode,
  input  logic [WIDTH-1:0]       ParallelIn,
  input  logic                   SerialInL,
  input  logic                   SerialInR,
  output logic [WIDTH-1:0]       Q,
  output logic [WIDTH-1:0]       Qbar,
  output logic                   SerialOutL,
  output logic                   SerialOutR,
  output logic [$clog2(WIDTH):0] ShiftCount,
  output logic                   WordDone
);

  mode_e            mode;
  logic [WIDTH-1:0] q_q, q_d;
  logic             step, clear;

  assign mode  = mode_e'(Mode);
  assign step  = is_step(mode);
  assign clear = is_clear(mode);

  // Next register contents for the selected operation.
  always_comb begin
    q_d = q_q;
    case (mode)
      MODE_LOAD:   q_d = ParallelIn;
      MODE_SHL:    q_d = {q_q[WIDTH-2:0], SerialInL};
      MODE_SHR:    q_d = {SerialInR, q_q[WIDTH-1:1]};
      MODE_ROL:    q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      MODE_ROR:    q_d = {q_q[0], q_q[WIDTH-1:1]};
      MODE_CLEAR:  q_d = '0;
      MODE_INVERT: q_d = ~q_q;
      default:     q_d = q_q;
    endcase
  end

  // Data register with asynchronous reset and clock enable.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      q_q <= RESET_VALUE;
    end else if (Enable) begin
      q_q <= q_d;
    end
  end

  usr_step_counter #(
    .WIDTH (WIDTH)
  ) u_step_counter (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .en_i    (Enable),
    .step_i  (step),
    .clear_i (clear),
    .count_o (ShiftCount),
    .done_o  (WordDone)
  );

  assign Q          = q_q;
  assign Qbar       = ~q_q;
  assign SerialOutL = q_q[WIDTH-1];
  assign SerialOutR = q_q[0];

endmodule
